// File: rtl/tank_sensor_emulator_if.sv
// Actuator/sensor bundle between the irrigation controller and the tank plant model.
// SENSOR_FAULT_EN adds the fault_inj stuck-at-1 control for the level switches.
interface tank_sensor_emulator_if #(
    parameter int LEVEL_W = 8
);
    logic               Bs;
    logic               Vs;
    logic               Ve;
    logic               load_en;
    logic [LEVEL_W-1:0] load_level;
`ifdef SENSOR_FAULT_EN
    logic [2:0]         fault_inj;
`endif
    logic               H;
    logic               M;
    logic               L;
    logic               Us;
    logic [LEVEL_W-1:0] level;
    logic               overflow;
    logic               dry_run;

`ifdef SENSOR_FAULT_EN
    modport master (
        output Bs, Vs, Ve, load_en, load_level, fault_inj,
        input  H, M, L, Us, level, overflow, dry_run
    );
    modport slave (
        input  Bs, Vs, Ve, load_en, load_level, fault_inj,
        output H, M, L, Us, level, overflow, dry_run
    );
`else
    modport master (
        output Bs, Vs, Ve, load_en, load_level,
        input  H, M, L, Us, level, overflow, dry_run
    );
    modport slave (
        input  Bs, Vs, Ve, load_en, load_level,
        output H, M, L, Us, level, overflow, dry_run
    );
`endif
endinterface

// File: rtl/tank_sensor_emulator.sv
// Closed-loop tank/soil plant model: turns pump/valve commands into level switches and humidity flag.
// Optional macro SENSOR_FAULT_EN enables stuck-at-1 injection on the H/M/L switch outputs.
module tank_sensor_emulator #(
    parameter int LEVEL_W    = 8,
    parameter int FULL_LEVEL = 200,
    parameter int H_THRESH   = 180,
    parameter int M_THRESH   = 100,
    parameter int L_THRESH   = 30,
    parameter int FILL_STEP  = 4,
    parameter int SPRK_STEP  = 3,
    parameter int DRIP_STEP  = 1,
    parameter int PUMP_DELAY = 3,
    parameter int US_THRESH  = 120,
    parameter int TICK_DIV   = 1000
) (
    input  logic                   clock,
    input  logic                   reset,
    tank_sensor_emulator_if.slave  bus
);
    localparam int SW      = LEVEL_W + 2;
    localparam int SPIN_W  = (PUMP_DELAY > 1) ? $clog2(PUMP_DELAY) : 1;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [SPIN_W-1:0]  SPIN_LAST  = SPIN_W'(PUMP_DELAY - 1);

    localparam logic [LEVEL_W-1:0] FULL_L = LEVEL_W'(FULL_LEVEL);
    localparam logic [LEVEL_W-1:0] H_TH   = LEVEL_W'(H_THRESH);
    localparam logic [LEVEL_W-1:0] M_TH   = LEVEL_W'(M_THRESH);
    localparam logic [LEVEL_W-1:0] L_TH   = LEVEL_W'(L_THRESH);
    localparam logic [LEVEL_W-1:0] US_TH  = LEVEL_W'(US_THRESH);

    localparam logic signed [SW-1:0] ZERO_S      = '0;
    localparam logic signed [SW-1:0] FULL_S      = SW'(FULL_LEVEL);
    localparam logic signed [SW-1:0] MOIST_MAX_S = SW'((1 << LEVEL_W) - 1);
    localparam logic signed [SW-1:0] FILL_S      = SW'(FILL_STEP);
    localparam logic signed [SW-1:0] SPRK_S      = SW'(SPRK_STEP);
    localparam logic signed [SW-1:0] DRIP_S      = SW'(DRIP_STEP);
    localparam logic signed [SW-1:0] WET2_S      = SW'(2);
    localparam logic signed [SW-1:0] WET1_S      = SW'(1);
    localparam logic signed [SW-1:0] DRY1_S      = -SW'(1);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SPINUP = 2'd1,
        RUN    = 2'd2
    } pump_state_t;

    function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [SW-1:0] v);
        if (v < ZERO_S)      return '0;
        else if (v > FULL_S) return FULL_L;
        else                 return v[LEVEL_W-1:0];
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_moist(input logic signed [SW-1:0] v);
        if (v < ZERO_S)           return '0;
        else if (v > MOIST_MAX_S) return '1;
        else                      return v[LEVEL_W-1:0];
    endfunction

    pump_state_t          state_q, state_nxt;
    logic [SPIN_W-1:0]    spin_q, spin_nxt;
    logic [PRESC_W-1:0]   presc_q;
    logic [LEVEL_W-1:0]   level_q, level_nxt;
    logic [LEVEL_W-1:0]   moist_q, moist_nxt;
    logic                 h_q, m_q, l_q, us_q;
    logic                 overflow_q, dry_run_q;
    logic                 tick;
    logic [2:0]           fault;
    logic signed [SW-1:0] delta, level_sum, moist_inc, moist_sum;

`ifdef SENSOR_FAULT_EN
    assign fault = bus.fault_inj;
`else
    assign fault = 3'b000;
`endif

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_nxt = state_q;
        spin_nxt  = spin_q;
        if (tick) begin
            case (state_q)
                OFF: begin
                    if (bus.Bs) begin
                        state_nxt = SPINUP;
                        spin_nxt  = '0;
                    end
                end
                SPINUP: begin
                    if (!bus.Bs)                 state_nxt = OFF;
                    else if (spin_q == SPIN_LAST) state_nxt = RUN;
                    else                          spin_nxt  = spin_q + SPIN_W'(1);
                end
                RUN: begin
                    if (!bus.Bs) state_nxt = OFF;
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    // Level and moisture deltas use the pump state before this tick's transition.
    always_comb begin
        delta     = ((state_q == RUN) ? FILL_S : ZERO_S)
                  - (bus.Vs ? SPRK_S : ZERO_S)
                  - (bus.Ve ? DRIP_S : ZERO_S);
        level_sum = $signed({2'b00, level_q}) + delta;

        if (bus.load_en)
            level_nxt = (bus.load_level > FULL_L) ? FULL_L : bus.load_level;
        else if (tick)
            level_nxt = sat_level(level_sum);
        else
            level_nxt = level_q;

        if (bus.Vs && level_q != '0)      moist_inc = WET2_S;
        else if (bus.Ve && level_q != '0) moist_inc = WET1_S;
        else                              moist_inc = DRY1_S;
        moist_sum = $signed({2'b00, moist_q}) + moist_inc;
        moist_nxt = tick ? sat_moist(moist_sum) : moist_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OFF;
            spin_q     <= '0;
            presc_q    <= '0;
            level_q    <= '0;
            moist_q    <= '0;
            h_q        <= 1'b0;
            m_q        <= 1'b0;
            l_q        <= 1'b0;
            us_q       <= 1'b0;
            overflow_q <= 1'b0;
            dry_run_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            spin_q     <= spin_nxt;
            presc_q    <= tick ? '0 : presc_q + PRESC_W'(1);
            level_q    <= level_nxt;
            moist_q    <= moist_nxt;
            // Switches are sampled from the registered level, hence one cycle behind it.
            h_q        <= (level_q >= H_TH) | fault[2];
            m_q        <= (level_q >= M_TH) | fault[1];
            l_q        <= (level_q >= L_TH) | fault[0];
            us_q       <= (moist_q >= US_TH);
            overflow_q <= overflow_q | (tick && state_q == RUN && level_q == FULL_L);
            dry_run_q  <= dry_run_q | (tick && (bus.Vs || bus.Ve) && level_q == '0);
        end
    end

    assign bus.H        = h_q;
    assign bus.M        = m_q;
    assign bus.L        = l_q;
    assign bus.Us       = us_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.dry_run  = dry_run_q;

endmodule

// File: tb/tb_tank_sensor_emulator.sv
// Directed bench for tank_sensor_emulator: fast instance (tick every cycle) plus a prescaled one.
// Build with SENSOR_FAULT_EN defined to also exercise the stuck-at-1 switch injection.
module tb_tank_sensor_emulator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst_s = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    tank_sensor_emulator_if #(.LEVEL_W(8)) mif ();
    tank_sensor_emulator_if #(.LEVEL_W(8)) sif ();

    tank_sensor_emulator #(.TICK_DIV(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (mif)
    );

    tank_sensor_emulator #(.TICK_DIV(4)) u_slow (
        .clock (clock),
        .reset (rst_s),
        .bus   (sif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mif.Bs = 0; mif.Vs = 0; mif.Ve = 0; mif.load_en = 0; mif.load_level = '0;
        sif.Bs = 0; sif.Vs = 0; sif.Ve = 0; sif.load_en = 0; sif.load_level = '0;
`ifdef SENSOR_FAULT_EN
        mif.fault_inj = 3'b000;
        sif.fault_inj = 3'b000;
`endif
        step(2);
        chk("rst_level", mif.level, 0);
        chk("rst_H", mif.H, 0);
        chk("rst_M", mif.M, 0);
        chk("rst_L", mif.L, 0);
        chk("rst_Us", mif.Us, 0);
        chk("rst_ovf", mif.overflow, 0);
        chk("rst_dry", mif.dry_run, 0);

        // Fill: SPINUP occupies three ticks, RUN adds 4 per tick from the following tick.
        reset = 0; mif.Bs = 1;
        step(4);  chk("spinup_level", mif.level, 0);
        step(1);  chk("run_first", mif.level, 4);
        step(7);  chk("fill_32", mif.level, 32);   chk("L_lag", mif.L, 0);
        step(1);  chk("fill_36", mif.level, 36);   chk("L_set", mif.L, 1);
        step(16); chk("fill_100", mif.level, 100); chk("M_lag", mif.M, 0);
        step(1);  chk("M_set", mif.M, 1);
        step(19); chk("fill_180", mif.level, 180); chk("H_lag", mif.H, 0);
        step(1);  chk("H_set", mif.H, 1);          chk("fill_184", mif.level, 184);
        step(4);  chk("fill_200", mif.level, 200); chk("ovf_not_yet", mif.overflow, 0);
        step(1);  chk("sat_200", mif.level, 200);  chk("ovf_set", mif.overflow, 1);

        // Sprinkler drain from a preset level.
        mif.load_en = 1; mif.load_level = 8'd150; mif.Bs = 0; mif.Vs = 1;
        step(1);  chk("load_150", mif.level, 150); chk("H_from_200", mif.H, 1);
        mif.load_en = 0;
        step(1);  chk("drain_147", mif.level, 147); chk("H_clr", mif.H, 0); chk("M_hold", mif.M, 1);
        step(16); chk("drain_99", mif.level, 99);  chk("M_lag_fall", mif.M, 1);
        step(1);  chk("drain_96", mif.level, 96);  chk("M_clr", mif.M, 0);

        // Both valves on a nearly empty tank: floor at 0, then dry_run.
        mif.load_en = 1; mif.load_level = 8'd2; mif.Ve = 1;
        step(1);  chk("load_2", mif.level, 2);     chk("dry_not_yet", mif.dry_run, 0);
        mif.load_en = 0;
        step(1);  chk("floor_0", mif.level, 0);    chk("dry_still_0", mif.dry_run, 0);
        step(1);  chk("dry_set", mif.dry_run, 1);  chk("stay_0", mif.level, 0);

        // Short pump pulse never reaches RUN.
        mif.Vs = 0; mif.Ve = 0; mif.load_en = 1; mif.load_level = 8'd60;
        step(1);  chk("load_60", mif.level, 60);
        mif.load_en = 0; mif.Bs = 1;
        step(2);
        mif.Bs = 0;
        step(1);  chk("pulse_level", mif.level, 60);
        step(4);  chk("pulse_level2", mif.level, 60);
        chk("pulse_L", mif.L, 1); chk("pulse_M", mif.M, 0); chk("pulse_H", mif.H, 0);

        // Reset while RUN with load_en asserted.
        mif.load_en = 1; mif.load_level = 8'd100; mif.Bs = 1;
        step(5);  chk("run_hold_100", mif.level, 100); chk("run_M", mif.M, 1);
        reset = 1;
        step(1);
        chk("mid_rst_level", mif.level, 0);
        chk("mid_rst_H", mif.H, 0);
        chk("mid_rst_M", mif.M, 0);
        chk("mid_rst_L", mif.L, 0);
        chk("mid_rst_Us", mif.Us, 0);
        chk("mid_rst_ovf", mif.overflow, 0);
        chk("mid_rst_dry", mif.dry_run, 0);
        reset = 0; mif.load_en = 0;
        step(1);  chk("post_rst_off", mif.level, 0);
        step(1);  chk("post_rst_spin", mif.level, 0); chk("post_rst_dry", mif.dry_run, 0);

        // Load clamps to FULL_LEVEL; sprinkler wets soil until Us trips.
        mif.Bs = 0; mif.Vs = 1; mif.load_en = 1; mif.load_level = 8'd255;
        step(1);  chk("load_clamp", mif.level, 200); chk("dry_empty_valve", mif.dry_run, 1);
        mif.load_en = 0;
        step(60); chk("wet_level_20", mif.level, 20); chk("Us_lag", mif.Us, 0);
        step(1);  chk("Us_set", mif.Us, 1);           chk("wet_level_17", mif.level, 17);
        mif.Vs = 0;

        // Prescaled instance: one tick every four cycles.
        step(1);
        rst_s = 0; sif.load_en = 1; sif.load_level = 8'd10;
        step(1);  chk("slow_load", sif.level, 10);
        sif.load_en = 0; sif.Ve = 1;
        step(2);  chk("slow_hold", sif.level, 10);
        step(1);  chk("slow_tick1", sif.level, 9);
        step(3);  chk("slow_hold2", sif.level, 9);
        step(1);  chk("slow_tick2", sif.level, 8);  chk("slow_dry", sif.dry_run, 0);

`ifdef SENSOR_FAULT_EN
        mif.load_en = 1; mif.load_level = 8'd50; mif.fault_inj = 3'b100;
        step(1);  chk("flt_load", mif.level, 50);
        mif.load_en = 0;
        step(1);
        chk("flt_H", mif.H, 1); chk("flt_M", mif.M, 0); chk("flt_L", mif.L, 1);
        mif.fault_inj = 3'b000;
        step(1);  chk("flt_H_clr", mif.H, 0); chk("flt_level", mif.level, 50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
